// File: rtl/byte_block_assembler.sv
// Packs a serial byte stream little-endian into REGISTER_SIZE-bit words, buffers one
// BITS_IN_NUM-bit number in RAM, then streams it out LSW first. Optional: BYTE_BLOCK_ASSEMBLER_OVERRUN_EN.
module byte_block_assembler #(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM   = 4096
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [7:0]               data_in,
    input  logic                     valid_in,
    output logic                     byte_ready_out,
    input  logic                     ready_in,
    output logic [REGISTER_SIZE-1:0] data_out,
    output logic                     valid_out,
    output logic                     last_out
`ifdef BYTE_BLOCK_ASSEMBLER_OVERRUN_EN
    ,
    output logic                     overrun_out
`endif
);

    localparam int NUM_BLOCKS      = BITS_IN_NUM / REGISTER_SIZE;
    localparam int BYTES_PER_BLOCK = REGISTER_SIZE / 8;
    localparam int BC_W = (BYTES_PER_BLOCK > 1) ? $clog2(BYTES_PER_BLOCK) : 1;
    localparam int WC_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    typedef enum logic {
        S_COLLECTING,
        S_DRAINING
    } state_t;

    state_t                   state_q, state_d;
    logic [BC_W-1:0]          byte_cnt_q, byte_cnt_d;
    logic [WC_W-1:0]          word_cnt_q, word_cnt_d;
    logic [WC_W-1:0]          rd_cnt_q, rd_cnt_d;
    logic [REGISTER_SIZE-1:0] word_q, word_d;
    logic [REGISTER_SIZE-1:0] data_out_q, data_out_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic                     wr_en;
    logic [REGISTER_SIZE-1:0] wr_word;

    logic [REGISTER_SIZE-1:0] mem [NUM_BLOCKS];

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        word_d     = word_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        last_d     = last_q;
        wr_en      = 1'b0;
        wr_word    = word_q;

        case (state_q)
            S_COLLECTING: begin
                if (valid_in) begin
                    for (int k = 0; k < BYTES_PER_BLOCK; k++) begin
                        if (byte_cnt_q == BC_W'(k)) wr_word[8*k +: 8] = data_in;
                    end
                    word_d = wr_word;
                    if (byte_cnt_q == BC_W'(BYTES_PER_BLOCK - 1)) begin
                        byte_cnt_d = '0;
                        wr_en      = 1'b1;
                        if (word_cnt_q == WC_W'(NUM_BLOCKS - 1)) begin
                            word_cnt_d = '0;
                            state_d    = S_DRAINING;
                        end else begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAINING: begin
                // The idle cycle between words is the registered RAM read of rd_cnt_q.
                if (!valid_q) begin
                    data_out_d = mem[rd_cnt_q];
                    valid_d    = 1'b1;
                    last_d     = (rd_cnt_q == WC_W'(NUM_BLOCKS - 1));
                end else if (ready_in) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (rd_cnt_q == WC_W'(NUM_BLOCKS - 1)) begin
                        rd_cnt_d = '0;
                        state_d  = S_COLLECTING;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_COLLECTING;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (wr_en) mem[word_cnt_q] <= wr_word;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_COLLECTING;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            rd_cnt_q   <= '0;
            word_q     <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            word_q     <= word_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

    assign byte_ready_out = (state_q == S_COLLECTING);
    assign data_out       = data_out_q;
    assign valid_out      = valid_q;
    assign last_out       = valid_q & last_q;

`ifdef BYTE_BLOCK_ASSEMBLER_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q | (valid_in & (state_q == S_DRAINING));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) overrun_q <= 1'b0;
        else        overrun_q <= overrun_d;
    end

    assign overrun_out = overrun_q;
`endif

endmodule

// File: tb/tb_byte_block_assembler.sv
// Bench for byte_block_assembler with NUM_BLOCKS=4: per-cycle comparison against a
// byte-list/word-queue model plus directed literal expectations.
module tb_byte_block_assembler;

    localparam int NB  = 4;
    localparam int BPB = 4;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic        valid_in = 1'b0;
    logic        byte_ready_out;
    logic        ready_in = 1'b1;
    logic [31:0] data_out;
    logic        valid_out;
    logic        last_out;
`ifdef BYTE_BLOCK_ASSEMBLER_OVERRUN_EN
    logic        overrun_out;
`endif

    byte_block_assembler #(.REGISTER_SIZE(32), .BITS_IN_NUM(128)) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .byte_ready_out(byte_ready_out),
        .ready_in      (ready_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .last_out      (last_out)
`ifdef BYTE_BLOCK_ASSEMBLER_OVERRUN_EN
        ,
        .overrun_out   (overrun_out)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Model: a number is the list of the 16 accepted bytes; the drain walks a word list.
    bit          started = 0;
    bit          m_coll = 1;
    int          m_nbytes = 0;
    logic [7:0]  m_bytes [NB*BPB];
    logic [31:0] m_words [NB];
    int          m_widx = 0;
    bit          m_valid = 0;
    logic [31:0] m_last_xfer = '0;
    bit          m_ovr = 0;

    always @(posedge clk) begin
        if (rst_in) begin
            started = 1;
            m_coll = 1; m_nbytes = 0; m_widx = 0; m_valid = 0;
            m_last_xfer = '0; m_ovr = 0;
        end else begin
            if (valid_in && !m_coll) m_ovr = 1;
            if (m_coll) begin
                if (valid_in) begin
                    m_bytes[m_nbytes] = data_in;
                    m_nbytes++;
                    if (m_nbytes == NB*BPB) begin
                        for (int i = 0; i < NB; i++)
                            for (int j = 0; j < BPB; j++)
                                m_words[i][8*j +: 8] = m_bytes[BPB*i + j];
                        m_coll = 0; m_nbytes = 0; m_widx = 0; m_valid = 0;
                    end
                end
            end else if (m_valid) begin
                if (ready_in) begin
                    m_last_xfer = m_words[m_widx];
                    m_widx++;
                    m_valid = 0;
                    if (m_widx == NB) begin
                        m_coll = 1;
                        m_widx = 0;
                    end
                end
            end else begin
                m_valid = 1;
            end
        end
    end

    logic [31:0] got_w [$];
    bit          got_l [$];

    always @(negedge clk) begin
        if (started) begin
            chk("byte_ready", {31'b0, byte_ready_out}, {31'b0, m_coll});
            chk("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
            chk("last_out", {31'b0, last_out}, {31'b0, (m_valid && m_widx == NB-1)});
            chk("data_out", data_out, m_valid ? m_words[m_widx] : m_last_xfer);
`ifdef BYTE_BLOCK_ASSEMBLER_OVERRUN_EN
            chk("overrun_out", {31'b0, overrun_out}, {31'b0, m_ovr});
`endif
            if (valid_out && ready_in && !rst_in) begin
                got_w.push_back(data_out);
                got_l.push_back(last_out);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        valid_in = 1'b0;
        repeat (gap) tick();
        w = 0;
        while (!byte_ready_out && w < 500) begin
            tick();
            w++;
        end
        if (w >= 500) chk("byte_ready_timeout", {31'b0, byte_ready_out}, 32'd1);
        valid_in = 1'b1;
        data_in  = b;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic send_num(input logic [7:0] base, input int gapmax);
        for (int i = 0; i < NB*BPB; i++)
            send_byte(base + 8'(i), (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    endtask

    task automatic wait_words(input int n);
        int w = 0;
        while (got_w.size() < n && w < 300) begin
            tick();
            w++;
        end
        chk("drain_count", got_w.size(), n);
    endtask

    task automatic expect_words(input int off, input logic [7:0] base);
        logic [31:0] e;
        for (int i = 0; i < NB; i++) begin
            for (int j = 0; j < BPB; j++) e[8*j +: 8] = base + 8'(BPB*i + j);
            if (got_w.size() > off + i) begin
                chk("word", got_w[off+i], e);
                chk("word_last", {31'b0, got_l[off+i]}, {31'b0, (i == NB-1)});
            end
        end
    endtask

    task automatic clear_got();
        got_w.delete();
        got_l.delete();
    endtask

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_last", {31'b0, last_out}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_byte_ready", {31'b0, byte_ready_out}, 32'd1);
        tick();
        rst_in = 1'b0;

        // consecutive bytes, exact drain timing
        clear_got();
        send_num(8'h00, 0);
        @(negedge clk);
        chk("t1_first_drain_valid", {31'b0, valid_out}, 32'd0);
        chk("t1_first_drain_ready", {31'b0, byte_ready_out}, 32'd0);
        @(negedge clk);
        chk("t1_valid_rise", {31'b0, valid_out}, 32'd1);
        chk("t1_first_word", data_out, 32'h03020100);
        wait_words(4);
        if (got_w.size() == 4) begin
            chk("t1_w0", got_w[0], 32'h03020100);
            chk("t1_w1", got_w[1], 32'h07060504);
            chk("t1_w2", got_w[2], 32'h0B0A0908);
            chk("t1_w3", got_w[3], 32'h0F0E0D0C);
            chk("t1_last", {28'b0, got_l[0], got_l[1], got_l[2], got_l[3]}, 32'h1);
        end
        chk("t1_ready_after", {31'b0, byte_ready_out}, 32'd1);

        // random gaps between bytes
        clear_got();
        send_num(8'h00, 4);
        wait_words(4);
        expect_words(0, 8'h00);

        // backpressure
        clear_got();
        ready_in = 1'b0;
        send_num(8'h00, 0);
        begin
            int w = 0;
            while (!valid_out && w < 50) begin tick(); w++; end
        end
        repeat (10) begin
            @(negedge clk);
            chk("t3_hold_valid", {31'b0, valid_out}, 32'd1);
            chk("t3_hold_data", data_out, 32'h03020100);
        end
        tick();
        ready_in = 1'b1;
        wait_words(4);
        expect_words(0, 8'h00);

        // bytes during drain are dropped
        clear_got();
        ready_in = 1'b0;
        send_num(8'h40, 0);
        data_in = 8'hFF;
        valid_in = 1'b1;
        repeat (5) tick();
        valid_in = 1'b0;
        ready_in = 1'b1;
        wait_words(4);
        expect_words(0, 8'h40);
`ifdef BYTE_BLOCK_ASSEMBLER_OVERRUN_EN
        chk("t4_overrun", {31'b0, overrun_out}, 32'd1);
`endif
        clear_got();
        send_num(8'h20, 0);
        wait_words(4);
        expect_words(0, 8'h20);
`ifdef BYTE_BLOCK_ASSEMBLER_OVERRUN_EN
        chk("t4_overrun_sticky", {31'b0, overrun_out}, 32'd1);
`endif

        // reset mid-collection
        for (int i = 0; i < 6; i++) send_byte(8'h50 + 8'(i), 0);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        clear_got();
        send_num(8'h10, 0);
        wait_words(4);
        expect_words(0, 8'h10);
        if (got_w.size() > 0) chk("t5_first_word", got_w[0], 32'h13121110);

        // reset mid-drain
        clear_got();
        send_num(8'h60, 0);
        wait_words(1);
        rst_in = 1'b1;
        tick();
        @(negedge clk);
        chk("t5_rst_valid", {31'b0, valid_out}, 32'd0);
        chk("t5_rst_ready", {31'b0, byte_ready_out}, 32'd1);
        tick();
        rst_in = 1'b0;

        // two numbers back-to-back
        clear_got();
        send_num(8'h30, 0);
        send_num(8'hA0, 0);
        wait_words(8);
        expect_words(0, 8'h30);
        expect_words(4, 8'hA0);
        if (got_w.size() == 8) begin
            chk("t6_w4", got_w[4], 32'hA3A2A1A0);
            chk("t6_w7", got_w[7], 32'hAFAEADAC);
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
